// File: rtl/mem_arbiter.sv
// Two-port (instruction/data) arbiter in front of a single-port word memory.
// Define ARB_ROUND_ROBIN_EN to alternate between ports on contention; otherwise the data port wins.
module mem_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_ack,
    output logic [DW-1:0] i_rdata,
    output logic          i_err,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ack,
    output logic [DW-1:0] d_rdata,
    output logic          d_err,
    output logic          mem_ren,
    output logic          mem_wen,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    input  logic [DW-1:0] mem_dout
);

    typedef enum logic [1:0] {IDLE, ACC, RESP} state_t;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    state_t        state;
    state_t        nextState;
    logic          lastGrant;
    logic          winner;
    logic          anyReq;
    logic          outOfRange;
    logic [AW-1:0] addrReg;
    logic          weReg;
    logic [DW-1:0] wdataReg;
    logic [DW-1:0] iRdataReg;
    logic [DW-1:0] dRdataReg;

    assign anyReq     = i_req | d_req;
    assign outOfRange = |addrReg[AW-1:10];
    assign i_rdata    = iRdataReg;
    assign d_rdata    = dRdataReg;

    // lastGrant doubles as the current owner, so it also steers the ack in RESP.
    always_comb begin
        winner = d_req ? PORT_D : PORT_I;
`ifdef ARB_ROUND_ROBIN_EN
        if (i_req && d_req) begin
            winner = (lastGrant == PORT_D) ? PORT_I : PORT_D;
        end
`endif
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lastGrant <= PORT_D;
            addrReg   <= '0;
            weReg     <= 1'b0;
            wdataReg  <= '0;
        end else if (state == IDLE && anyReq) begin
            lastGrant <= winner;
            addrReg   <= (winner == PORT_D) ? d_addr : i_addr;
            weReg     <= (winner == PORT_D) & d_we;
            wdataReg  <= (winner == PORT_D) ? d_wdata : '0;
        end
    end

    // Read data lands in the owner's rdata register; writes and errors leave it alone.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            iRdataReg <= '0;
            dRdataReg <= '0;
        end else if (state == ACC && !weReg && !outOfRange) begin
            if (lastGrant == PORT_D) begin
                dRdataReg <= mem_dout;
            end else begin
                iRdataReg <= mem_dout;
            end
        end
    end

    always_comb begin
        nextState = state;
        mem_ren   = 1'b0;
        mem_wen   = 1'b0;
        mem_addr  = '0;
        mem_din   = '0;
        i_ack     = 1'b0;
        d_ack     = 1'b0;
        i_err     = 1'b0;
        d_err     = 1'b0;
        case (state)
            IDLE: begin
                if (anyReq) begin
                    nextState = ACC;
                end
            end
            ACC: begin
                nextState = RESP;
                mem_ren   = !weReg && !outOfRange;
                mem_wen   = weReg && !outOfRange;
                mem_addr  = addrReg;
                mem_din   = wdataReg;
            end
            RESP: begin
                nextState = IDLE;
                i_ack     = (lastGrant == PORT_I);
                d_ack     = (lastGrant == PORT_D);
                i_err     = (lastGrant == PORT_I) && outOfRange;
                d_err     = (lastGrant == PORT_D) && outOfRange;
            end
            default: nextState = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a behavioural word memory on the shared reset.
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          iReq = 1'b0;
    logic [AW-1:0] iAddr = '0;
    logic          iAck;
    logic [DW-1:0] iRdata;
    logic          iErr;
    logic          dReq = 1'b0;
    logic          dWe = 1'b0;
    logic [AW-1:0] dAddr = '0;
    logic [DW-1:0] dWdata = '0;
    logic          dAck;
    logic [DW-1:0] dRdata;
    logic          dErr;
    logic          memRen;
    logic          memWen;
    logic [AW-1:0] memAddr;
    logic [DW-1:0] memDin;
    logic [DW-1:0] memDout;

    int testsRun = 0;
    int testsFailed = 0;

    logic [DW-1:0] mem [0:1023];
    logic [DW-1:0] modelMem [0:1023];
    logic [DW-1:0] iRdataExp = '0;
    logic [DW-1:0] dRdataExp = '0;
    logic          prevIAck = 1'b0;
    logic          prevDAck = 1'b0;

    always #5 clock = ~clock;

    mem_arbiter #(.AW(AW), .DW(DW)) dut (
        .clock(clock), .reset(reset),
        .i_req(iReq), .i_addr(iAddr), .i_ack(iAck), .i_rdata(iRdata), .i_err(iErr),
        .d_req(dReq), .d_we(dWe), .d_addr(dAddr), .d_wdata(dWdata),
        .d_ack(dAck), .d_rdata(dRdata), .d_err(dErr),
        .mem_ren(memRen), .mem_wen(memWen), .mem_addr(memAddr), .mem_din(memDin),
        .mem_dout(memDout)
    );

    always @(posedge clock) begin
        if (reset && memWen) mem[memAddr[9:0]] <= memDin;
    end
    assign memDout = mem[memAddr[9:0]];

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Invariants sampled mid-cycle for the whole run.
    always @(negedge clock) begin
        checkOutput("ren_wen_exclusive", {31'b0, memRen & memWen}, 32'd0);
        checkOutput("i_ack_single_cycle", {31'b0, prevIAck & iAck}, 32'd0);
        checkOutput("d_ack_single_cycle", {31'b0, prevDAck & dAck}, 32'd0);
        prevIAck <= iAck;
        prevDAck <= dAck;
    end

    // One complete access on one port: request, ACC checks, RESP checks, release.
    task automatic applyStimulus(input logic port, input logic we, input logic [31:0] addr,
                                 input logic [31:0] wdata, input string tag);
        logic inRange;
        inRange = (addr[31:10] == 22'd0);
        if (port) begin
            dReq = 1'b1; dWe = we; dAddr = addr; dWdata = wdata;
        end else begin
            iReq = 1'b1; iAddr = addr;
        end
        tick();
        checkOutput({tag, "_acc_ren"}, {31'b0, memRen}, {31'b0, !we && inRange});
        checkOutput({tag, "_acc_wen"}, {31'b0, memWen}, {31'b0, we && inRange});
        checkOutput({tag, "_acc_noack"}, {30'b0, iAck, dAck}, 32'd0);
        if (inRange) checkOutput({tag, "_acc_addr"}, memAddr, addr);
        if (we && inRange) checkOutput({tag, "_acc_din"}, memDin, wdata);
        if (!we && inRange) begin
            if (port) dRdataExp = modelMem[addr[9:0]];
            else iRdataExp = modelMem[addr[9:0]];
        end
        if (we && inRange) modelMem[addr[9:0]] = wdata;
        tick();
        checkOutput({tag, "_resp_iack"}, {31'b0, iAck}, {31'b0, !port});
        checkOutput({tag, "_resp_dack"}, {31'b0, dAck}, {31'b0, port});
        checkOutput({tag, "_resp_err"}, {31'b0, port ? dErr : iErr}, {31'b0, !inRange});
        checkOutput({tag, "_resp_irdata"}, iRdata, iRdataExp);
        checkOutput({tag, "_resp_drdata"}, dRdata, dRdataExp);
        tick();
        iReq = 1'b0; dReq = 1'b0; dWe = 1'b0;
        checkOutput({tag, "_idle_ren"}, {31'b0, memRen}, 32'd0);
    endtask

    initial begin
        logic expWin;
        for (int i = 0; i < 1024; i++) begin
            mem[i] = '0;
            modelMem[i] = '0;
        end
        mem[5] = 32'hDEADBEEF; modelMem[5] = 32'hDEADBEEF;
        mem[3] = 32'h33333333; modelMem[3] = 32'h33333333;

        #12;
        checkOutput("reset_acks", {30'b0, iAck, dAck}, 32'd0);
        checkOutput("reset_mem_en", {30'b0, memRen, memWen}, 32'd0);
        checkOutput("reset_mem_addr", memAddr, 32'd0);
        checkOutput("reset_rdata", iRdata | dRdata, 32'd0);
        @(posedge clock); #1;
        reset = 1'b1;
        tick();

        applyStimulus(1'b0, 1'b0, 32'd5, 32'd0, "iread5");
        applyStimulus(1'b1, 1'b1, 32'd7, 32'h12345678, "dwrite7");
        applyStimulus(1'b1, 1'b0, 32'd7, 32'd0, "dread7");
        applyStimulus(1'b1, 1'b0, 32'h400, 32'd0, "door");

        // Both ports held high across four back-to-back accesses.
        iReq = 1'b1; iAddr = 32'd5;
        dReq = 1'b1; dWe = 1'b0; dAddr = 32'd7;
        for (int k = 0; k < 4; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
            expWin = (k % 2 == 1);
`else
            expWin = 1'b1;
`endif
            tick();
            checkOutput($sformatf("both%0d_addr", k), memAddr, expWin ? 32'd7 : 32'd5);
            tick();
            checkOutput($sformatf("both%0d_iack", k), {31'b0, iAck}, {31'b0, !expWin});
            checkOutput($sformatf("both%0d_dack", k), {31'b0, dAck}, {31'b0, expWin});
            checkOutput($sformatf("both%0d_rdata", k), expWin ? dRdata : iRdata,
                        expWin ? 32'h12345678 : 32'hDEADBEEF);
            tick();
        end
        iReq = 1'b0; dReq = 1'b0;
        tick();

        // Instruction request raised mid-access must be served next.
        dReq = 1'b1; dWe = 1'b0; dAddr = 32'd7;
        tick();
        iReq = 1'b1; iAddr = 32'd5;
        tick();
        checkOutput("late_dack", {31'b0, dAck}, 32'd1);
        tick();
        dReq = 1'b0;
        tick();
        checkOutput("late_i_ren", {31'b0, memRen}, 32'd1);
        checkOutput("late_i_addr", memAddr, 32'd5);
        tick();
        checkOutput("late_iack", {31'b0, iAck}, 32'd1);
        tick();
        iReq = 1'b0;
        tick();

        // Reset asserted during ACC of a write to word 3.
        dReq = 1'b1; dWe = 1'b1; dAddr = 32'd3; dWdata = 32'hAAAA5555;
        tick();
        checkOutput("rst_acc_wen", {31'b0, memWen}, 32'd1);
        #2 reset = 1'b0;
        #1;
        checkOutput("rst_wen_low", {31'b0, memWen}, 32'd0);
        checkOutput("rst_no_dack", {31'b0, dAck}, 32'd0);
        checkOutput("rst_rdata_clr", iRdata | dRdata, 32'd0);
        @(posedge clock); #1;
        checkOutput("rst_mem3_kept", mem[3], 32'h33333333);
        checkOutput("rst_still_idle", {31'b0, dAck | memWen}, 32'd0);
        reset = 1'b1;
        tick();
        checkOutput("rearb_wen", {31'b0, memWen}, 32'd1);
        checkOutput("rearb_addr", memAddr, 32'd3);
        tick();
        checkOutput("rearb_dack", {31'b0, dAck}, 32'd1);
        checkOutput("rearb_mem3", mem[3], 32'hAAAA5555);
        checkOutput("rearb_drdata", dRdata, 32'd0);
        tick();
        dReq = 1'b0; dWe = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
